// File: rtl/matrix_op_sequencer_pkg.sv
// rtl/matrix_op_sequencer_pkg.sv - shared opcodes, sizes, FSM encoding and address helpers
// Purpose: common definitions for the matrix command sequencer and its index generator.
// Ports: none (package).
package matrix_op_sequencer_pkg;

    localparam int MAX_N = 5;
    localparam int AW    = 5;

    // Same encoding the element ALU decodes.
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MULT  = 3'b010;
    localparam logic [2:0] OP_MULR  = 3'b011;
    localparam logic [2:0] OP_DET   = 3'b100;
    localparam logic [2:0] OP_TRANS = 3'b101;
    localparam logic [2:0] OP_OPP   = 3'b110;
    localparam logic [2:0] OP_CLR   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Row-major storage: address = row*MAX_N + col.
    function automatic logic [AW-1:0] rm_addr(input logic [2:0] row, input logic [2:0] col);
        return AW'(int'(row) * MAX_N + int'(col));
    endfunction

    function automatic logic size_ok(input logic [2:0] sz);
        return (int'(sz) >= 2) && (int'(sz) <= MAX_N);
    endfunction

endpackage

// File: rtl/matrix_op_sequencer_if.sv
// rtl/matrix_op_sequencer_if.sv - command, operand memory, ALU and result port bundle
// Purpose: groups every non-clock/reset signal of the sequencer.
// Ports: master = sequencer side, slave = front-end/memories/ALU side.
interface matrix_op_sequencer_if;
    import matrix_op_sequencer_pkg::*;

    logic                 start;
    logic [2:0]           op;
    logic [2:0]           size;
    logic signed [7:0]    scalar;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [AW-1:0]        a_addr;
    logic [AW-1:0]        b_addr;
    logic signed [7:0]    a_data;
    logic signed [7:0]    b_data;
    logic [2:0]           alu_op;
    logic signed [8:0]    alu_r1;
    logic signed [8:0]    alu_r2;
    logic [2:0]           alu_s;
    logic signed [7:0]    alu_out;
    logic                 c_we;
    logic [AW-1:0]        c_addr;
    logic signed [7:0]    c_data;

    modport master (
        input  start, op, size, scalar, a_data, b_data, alu_out,
        output busy, done, err, a_addr, b_addr, alu_op, alu_r1, alu_r2, alu_s,
               c_we, c_addr, c_data
    );

    modport slave (
        output start, op, size, scalar, a_data, b_data, alu_out,
        input  busy, done, err, a_addr, b_addr, alu_op, alu_r1, alu_r2, alu_s,
               c_we, c_addr, c_data
    );

endinterface

// File: rtl/matrix_op_sequencer_index_gen.sv
// rtl/matrix_op_sequencer_index_gen.sv - i/j/k loop counters and operand/result addresses
// Purpose: holds row (i), column (j) and inner (k) indices, flags loop ends and keeps
//          registered A, B and C addresses that always match the current indices.
// Ports: clk, rst_n; i_size (latched n); i_clear / i_step_k / i_step_elem advance
//        controls; i_mult / i_trans select address forms; o_k_last, o_elem_last end
//        flags; o_a_addr, o_b_addr, o_c_addr registered addresses.
module matrix_index_gen
    import matrix_op_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    i_size,
    input  logic          i_clear,
    input  logic          i_step_k,
    input  logic          i_step_elem,
    input  logic          i_mult,
    input  logic          i_trans,
    output logic          o_k_last,
    output logic          o_elem_last,
    output logic [AW-1:0] o_a_addr,
    output logic [AW-1:0] o_b_addr,
    output logic [AW-1:0] o_c_addr
);

    logic [2:0]    r_i, r_j, r_k;
    logic [2:0]    w_i_nxt, w_j_nxt, w_k_nxt;
    logic [2:0]    w_last;
    logic [AW-1:0] w_a_nxt, w_b_nxt, w_c_nxt;
    logic [AW-1:0] r_a_addr, r_b_addr, r_c_addr;

    assign w_last      = i_size - 3'd1;
    assign o_k_last    = (r_k == w_last);
    assign o_elem_last = (r_i == w_last) && (r_j == w_last);

    always_comb begin
        w_i_nxt = r_i;
        w_j_nxt = r_j;
        w_k_nxt = r_k;
        if (i_clear) begin
            w_i_nxt = 3'd0;
            w_j_nxt = 3'd0;
            w_k_nxt = 3'd0;
        end else if (i_step_elem) begin
            w_k_nxt = 3'd0;
            if (r_j == w_last) begin
                w_j_nxt = 3'd0;
                w_i_nxt = (r_i == w_last) ? 3'd0 : r_i + 3'd1;
            end else begin
                w_j_nxt = r_j + 3'd1;
            end
        end else if (i_step_k) begin
            w_k_nxt = o_k_last ? 3'd0 : r_k + 3'd1;
        end
    end

    // Addresses are computed from the next indices so the registered copies line up
    // with the indices in the same cycle (no one-cycle lag on a_addr/b_addr).
    always_comb begin
        w_c_nxt = rm_addr(w_i_nxt, w_j_nxt);
        w_b_nxt = i_mult ? rm_addr(w_k_nxt, w_j_nxt) : w_c_nxt;
        if (i_mult) begin
            w_a_nxt = rm_addr(w_i_nxt, w_k_nxt);
        end else if (i_trans) begin
            w_a_nxt = rm_addr(w_j_nxt, w_i_nxt);
        end else begin
            w_a_nxt = w_c_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i      <= 3'd0;
            r_j      <= 3'd0;
            r_k      <= 3'd0;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_c_addr <= '0;
        end else begin
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_a_addr <= w_a_nxt;
            r_b_addr <= w_b_nxt;
            r_c_addr <= w_c_nxt;
        end
    end

    assign o_a_addr = r_a_addr;
    assign o_b_addr = r_b_addr;
    assign o_c_addr = r_c_addr;

endmodule

// File: rtl/matrix_op_sequencer.sv
// rtl/matrix_op_sequencer.sv - matrix command sequencer driving the element ALU
// Purpose: accepts one matrix command, reads A/B elements, feeds the ALU, accumulates
//          products for multiply and writes the result matrix C.
// Ports: clk, rst_n (async active-low); bus (master modport): start/op/size/scalar
//        command, busy/done/err status, a_/b_ read ports, alu_* ALU port, c_* write port.
module matrix_op_sequencer
    import matrix_op_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_op_sequencer_if.master   bus
);

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_op;
    logic [2:0]        r_size;
    logic signed [7:0] r_scalar;
    logic signed [7:0] r_acc;
    logic              r_err;
    logic              w_accept;
    logic              w_clear, w_step_k, w_step_elem;
    logic              w_k_last, w_elem_last;
    logic [AW-1:0]     w_a_addr, w_b_addr, w_c_addr;

    assign w_accept = (r_state == ST_IDLE) && bus.start;

    matrix_index_gen u_index_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_size      (r_size),
        .i_clear     (w_clear),
        .i_step_k    (w_step_k),
        .i_step_elem (w_step_elem),
        .i_mult      (r_op == OP_MULT),
        .i_trans     (r_op == OP_TRANS),
        .o_k_last    (w_k_last),
        .o_elem_last (w_elem_last),
        .o_a_addr    (w_a_addr),
        .o_b_addr    (w_b_addr),
        .o_c_addr    (w_c_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_step_k    = 1'b0;
        w_step_elem = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_clear = 1'b1;
                    if (!size_ok(bus.size)) begin
                        w_state_nxt = ST_DONE;
                    end else if (bus.op == OP_DET) begin
                        w_state_nxt = ST_EXEC;
                    end else if (bus.op == OP_CLR) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_READ: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (r_op == OP_MULT) begin
                    w_step_k    = 1'b1;
                    w_state_nxt = w_k_last ? ST_WRITE : ST_READ;
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if ((r_op == OP_DET) || w_elem_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_step_elem = 1'b1;
                    w_state_nxt = (r_op == OP_CLR) ? ST_WRITE : ST_READ;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_acc doubles as the result register: element ops overwrite it, multiply sums
    // into it and clears it after each write, clear never touches it so C gets zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 3'd0;
            r_size   <= 3'd0;
            r_scalar <= 8'sd0;
            r_err    <= 1'b0;
            r_acc    <= 8'sd0;
        end else if (w_accept) begin
            r_op     <= bus.op;
            r_size   <= bus.size;
            r_scalar <= bus.scalar;
            r_err    <= !size_ok(bus.size);
            r_acc    <= 8'sd0;
        end else if (r_state == ST_EXEC) begin
            r_acc <= (r_op == OP_MULT) ? r_acc + bus.alu_out : bus.alu_out;
        end else if ((r_state == ST_WRITE) && (r_op == OP_MULT)) begin
            r_acc <= 8'sd0;
        end
    end

    // Operands reach the ALU combinationally from the read data during EXEC.
    always_comb begin
        bus.alu_r1 = 9'sd0;
        bus.alu_r2 = 9'sd0;
        if (r_state == ST_EXEC) begin
            case (r_op)
                OP_ADD, OP_SUB, OP_MULT: begin
                    bus.alu_r1 = {bus.a_data[7], bus.a_data};
                    bus.alu_r2 = {bus.b_data[7], bus.b_data};
                end
                OP_MULR: begin
                    bus.alu_r1 = {bus.a_data[7], bus.a_data};
                    bus.alu_r2 = {r_scalar[7], r_scalar};
                end
                OP_OPP: begin
                    bus.alu_r1 = {bus.a_data[7], bus.a_data};
                    bus.alu_r2 = -9'sd1;
                end
                OP_TRANS: begin
                    bus.alu_r1 = {bus.a_data[7], bus.a_data};
                    bus.alu_r2 = 9'sd1;
                end
                default: begin
                    bus.alu_r1 = 9'sd0;
                    bus.alu_r2 = 9'sd0;
                end
            endcase
        end
    end

    assign bus.busy   = (r_state == ST_READ) || (r_state == ST_EXEC) || (r_state == ST_WRITE);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.err    = (r_state == ST_DONE) && r_err;
    assign bus.a_addr = w_a_addr;
    assign bus.b_addr = w_b_addr;
    assign bus.alu_op = r_op;
    assign bus.alu_s  = r_size;
    assign bus.c_we   = (r_state == ST_WRITE);
    assign bus.c_addr = w_c_addr;
    assign bus.c_data = r_acc;

endmodule
